// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals for fifo_wr_arbiter.
// slave  : the arbiter's view (drives ready, FIFO write and grant status).
// master : the environment's view (drives requests and FIFO status).
// grant_cnt exists only when FIFO_WR_ARBITER_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 128
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_wr_data;
  logic                        fifo_full;
  logic                        fifo_almost_full;
  logic                        grant_valid;
  logic [ID_W-1:0]             grant_id;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N_REQ*16-1:0]         grant_cnt;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, grant_cnt
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, grant_cnt
  );
`else
  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
  );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: N_REQ requesters share one FIFO write port.
// A holder keeps the grant for up to BURST_LEN transfers, each word is
// written to the FIFO one cycle after it is accepted, and every change of
// holder passes through one IDLE cycle.
// Optional feature: define FIFO_WR_ARBITER_STATS_EN to add per-requester
// saturating 16-bit transfer counters on bus.grant_cnt.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arbiter_if.slave    bus
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gid;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] wr_data_p1;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  can_accept;
  logic                  xfer;
  logic                  leave;
  logic [N_REQ-1:0]      ready;
  logic                  grant_valid;

  // Round-robin search: first set bit at or after ptr, wrapping modulo N_REQ.
  // Returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] id;
    int              idx;
    found = 1'b0;
    id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  // Successor of a requester index, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  // Saturating 16-bit increment used by the transfer counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign {pick_found, pick_id} = rr_pick(bus.req_valid, rr_ptr);

  assign hold_valid = bus.req_valid[gid];
  assign hold_data  = bus.req_data[int'(gid)*DATA_WIDTH +: DATA_WIDTH];

  // A write already in flight plus one free entry means the FIFO is
  // effectively full for this cycle's accept.
  assign can_accept = !bus.fifo_full && !(vld_p1 && bus.fifo_almost_full);

  // Nothing is accepted while rst is high, so no word is lost to the abort.
  assign xfer  = (state == GRANT) && !rst && hold_valid && can_accept;
  assign leave = (state == GRANT) &&
                 ((xfer && (beat_cnt == LAST_BEAT)) || !hold_valid);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE grants to any requester, GRANT ends on the last
  // beat or when the holder stops requesting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (leave)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: only the holder sees ready, and only in GRANT.
  always_comb begin
    ready       = '0;
    grant_valid = (state == GRANT);
    if ((state == GRANT) && !rst) ready[gid] = can_accept;
  end

  // Grant holder, round-robin pointer and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gid      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if ((state == IDLE) && pick_found) gid <= pick_id;
      if (leave) begin
        rr_ptr   <= next_id(gid);
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // ---- stage p1: accepted word registered toward the FIFO ----
  // Write register; reset also clears the data word and kills a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) wr_data_p1 <= hold_data;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.grant_valid  = grant_valid;
  assign bus.grant_id     = gid;
  assign bus.fifo_wr_en   = vld_p1;
  assign bus.fifo_wr_data = wr_data_p1;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q;

  // Per-requester transfer counters, saturating at 0xFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q[gid] <= sat_inc16(cnt_q[gid]);
    end
  end

  assign bus.grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester models, a FIFO
// occupancy model and a write-data scoreboard, plus directed grant-order,
// burst-length, back-pressure, fill and mid-burst reset scenarios.
module tb_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 128;
  localparam int BURST_LEN  = 4;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int rem [N_REQ];
  int seq [N_REQ];
  logic [DATA_WIDTH-1:0] exp_q [$];
  int glog [$];
  int blog [$];
  int gaps [$];

  int cnt = 0;
  int wr_total = 0;
  int cur_beats = 0;
  int idle_run = 0;
  bit drain = 1'b1;
  bit force_full = 1'b0;
  bit force_af = 1'b0;
  bit pending = 1'b0;
  bit mon_en = 1'b0;
  bit prev_gv = 1'b0;
  bit wr_s = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] word(input int i, input int s);
    return {32'(s * 7 + 3), 32'(i), 32'(s), 32'hC0DE_0000 + 32'(i * 256 + s)};
  endfunction

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid[i] = (rem[i] > 0);
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = word(i, seq[i]);
    end
    bus.fifo_full        = force_full || (cnt >= DEPTH);
    bus.fifo_almost_full = force_af || (cnt == DEPTH - 1);
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // Pre-edge sampling: scoreboard the FIFO write, check ready, log grants,
  // and record the transfers that the coming edge will commit.
  task automatic sample();
    logic [N_REQ-1:0] exp_rdy;
    logic [DATA_WIDTH-1:0] w;
    wr_s = bus.fifo_wr_en;
    if (!mon_en) return;
    check_eq("wr_latency", bus.fifo_wr_en, pending);
    if (bus.fifo_wr_en === 1'b1) begin
      check_eq("no_wr_full", bus.fifo_full, 0);
      check_eq("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_eq("wr_data", bus.fifo_wr_data, w);
      end
    end
    exp_rdy = '0;
    if (bus.grant_valid && !rst)
      exp_rdy[bus.grant_id] = !bus.fifo_full && !(bus.fifo_wr_en && bus.fifo_almost_full);
    check_eq("ready", bus.req_ready, exp_rdy);
    if (bus.grant_valid && !prev_gv) begin
      glog.push_back(int'(bus.grant_id));
      gaps.push_back(idle_run);
    end
    if (!bus.grant_valid && prev_gv) begin
      blog.push_back(cur_beats);
      cur_beats = 0;
    end
    if (bus.grant_valid) idle_run = 0;
    else                 idle_run++;
    prev_gv = bus.grant_valid;
    pending = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        exp_q.push_back(word(i, seq[i]));
        seq[i]++;
        rem[i]--;
        pending = 1'b1;
        cur_beats++;
      end
    end
  endtask

  task automatic cycle();
    bit pop;
    drive();
    #1;
    sample();
    @(posedge clk);
    pop = drain && (cnt > 0);
    if (wr_s) begin
      cnt++;
      wr_total++;
    end
    if (pop) cnt--;
    if (cnt > DEPTH) cnt = DEPTH;
    #1;
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (exp_q.size() == 0) && !bus.grant_valid && !prev_gv && !pending;
    for (int i = 0; i < N_REQ; i++) if (rem[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic drain_all(input string tag);
    int n = 0;
    while (!all_quiet() && n < 400) begin
      cycle();
      n++;
    end
    check_eq(tag, all_quiet(), 1);
  endtask

  task automatic run_until_logs(input int ng, input int nb, input int budget, input string tag);
    int n = 0;
    while ((glog.size() < ng || blog.size() < nb) && n < budget) begin
      cycle();
      n++;
    end
    check_eq(tag, (glog.size() >= ng) && (blog.size() >= nb), 1);
  endtask

  task automatic run_until_beats(input int nbeats, input int budget, input string tag);
    int n = 0;
    while (cur_beats < nbeats && n < budget) begin
      cycle();
      n++;
    end
    check_eq(tag, cur_beats >= nbeats, 1);
  endtask

  task automatic clear_logs();
    glog.delete();
    blog.delete();
    gaps.delete();
  endtask

  task automatic stop_all();
    for (int i = 0; i < N_REQ; i++) rem[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1 [5] = '{0, 1, 2, 3, 0};
    int b2 [3] = '{4, 4, 2};
    int base;

    for (int i = 0; i < N_REQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    settle();
    check_eq("rst_wr_en",   bus.fifo_wr_en,   0);
    check_eq("rst_wr_data", bus.fifo_wr_data, 0);
    check_eq("rst_gvalid",  bus.grant_valid,  0);
    check_eq("rst_gid",     bus.grant_id,     0);
    check_eq("rst_ready",   bus.req_ready,    0);
    pending = 1'b0;
    mon_en  = 1'b1;
    rst     = 1'b0;

    // All four requesting: round-robin order, full bursts, one IDLE gap
    clear_logs();
    for (int i = 0; i < N_REQ; i++) rem[i] = 100;
    run_until_logs(5, 4, 80, "t1_progress");
    if (glog.size() >= 5 && blog.size() >= 4) begin
      for (int k = 0; k < 5; k++) check_eq($sformatf("t1_grant%0d", k), glog[k], g1[k]);
      for (int k = 0; k < 4; k++) check_eq($sformatf("t1_beats%0d", k), blog[k], 4);
      for (int k = 1; k < 5; k++) check_eq($sformatf("t1_gap%0d", k), gaps[k], 1);
    end
    stop_all();
    drain_all("t1_drain");

    // Single requester streaming 10 words: bursts 4,4,2
    clear_logs();
    base = wr_total;
    rem[2] = 10;
    drain_all("t2_drain");
    check_eq("t2_ngrants", glog.size(), 3);
    check_eq("t2_nbursts", blog.size(), 3);
    if (glog.size() == 3 && blog.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("t2_grant%0d", k), glog[k], 2);
        check_eq($sformatf("t2_beats%0d", k), blog[k], b2[k]);
      end
      check_eq("t2_gap1", gaps[1], 1);
      check_eq("t2_gap2", gaps[2], 1);
    end
    check_eq("t2_writes", wr_total - base, 10);

    // FIFO full for 5 cycles in the middle of a burst
    clear_logs();
    rem[1] = 8;
    run_until_beats(2, 20, "t3_reach_beat2");
    force_af = 1'b1;
    settle();
    check_eq("t3_af_wr_pending", bus.fifo_wr_en, 1);
    check_eq("t3_af_ready", bus.req_ready, 0);
    cycle();
    force_af   = 1'b0;
    force_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq($sformatf("t3_full_ready%0d", k), bus.req_ready, 0);
      check_eq($sformatf("t3_full_wr%0d", k), bus.fifo_wr_en, 0);
      check_eq($sformatf("t3_full_gv%0d", k), bus.grant_valid, 1);
      check_eq($sformatf("t3_full_gid%0d", k), bus.grant_id, 1);
      cycle();
    end
    force_full = 1'b0;
    drain_all("t3_drain");
    check_eq("t3_nbursts", blog.size(), 2);
    if (blog.size() == 2) begin
      check_eq("t3_beats0", blog[0], 4);
      check_eq("t3_beats1", blog[1], 4);
    end

    // Fill a depth-16 FIFO that is never read
    repeat (3) cycle();
    check_eq("t4_empty_start", cnt, 0);
    drain = 1'b0;
    base  = wr_total;
    rem[0] = 20;
    repeat (60) cycle();
    check_eq("t4_writes", wr_total - base, 16);
    check_eq("t4_level", cnt, DEPTH);
    check_eq("t4_held", bus.grant_valid, 1);
    check_eq("t4_left", rem[0], 4);
    drain = 1'b1;
    drain_all("t4_drain");

    // Reset during beat 2 of a grant
    clear_logs();
    rem[0] = 20;
    rem[3] = 20;
    run_until_beats(2, 20, "t5_reach_beat2");
    check_eq("t5_holder", glog.size() > 0 ? glog[0] : -1, 3);
    rst = 1'b1;
    settle();
    check_eq("t5_rst_ready", bus.req_ready, 0);
    cycle();
    rst = 1'b0;
    settle();
    check_eq("t5_wr_en",   bus.fifo_wr_en,   0);
    check_eq("t5_wr_data", bus.fifo_wr_data, 0);
    check_eq("t5_gvalid",  bus.grant_valid,  0);
    check_eq("t5_gid",     bus.grant_id,     0);
    check_eq("t5_ready",   bus.req_ready,    0);
    clear_logs();
    run_until_logs(1, 0, 10, "t5_regrant");
    check_eq("t5_first_grant", glog.size() > 0 ? glog[0] : -1, 0);
    stop_all();
    drain_all("t5_drain");

`ifdef FIFO_WR_ARBITER_STATS_EN
    // Transfer counters: 6 transfers from requester 1
    do_reset();
    settle();
    check_eq("t6_cnt_clear", bus.grant_cnt, 0);
    rem[1] = 6;
    drain_all("t6_drain");
    check_eq("t6_cnt1", bus.grant_cnt[31:16], 6);
    check_eq("t6_cnt_all", bus.grant_cnt, 64'h0000_0000_0006_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128, giving the FIFO word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the maximum beats per grant (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, N_REQ bits: per-requester word valid.
REQ-007 The block SHALL have port req_data, input, N_REQ*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: per-requester accept.
REQ-009 The block SHALL have port fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-010 The block SHALL have port fifo_wr_data, output, DATA_WIDTH bits: FIFO write word.
REQ-011 The block SHALL have port fifo_full, input, 1 bit: FIFO full.
REQ-012 The block SHALL have port fifo_almost_full, input, 1 bit: one free entry left (FIFO ALMOST_FULL=1).
REQ-013 The block SHALL have port grant_valid, output, 1 bit: a requester currently holds the grant.
REQ-014 The block SHALL have port grant_id, output, $clog2(N_REQ) bits: index of the current holder.

Function
REQ-015 The state machine SHALL have exactly two states, IDLE and GRANT.
REQ-016 In IDLE with any req_valid bit set, the block SHALL register a grant to the first set bit at or after rr_ptr, wrapping modulo N_REQ, and enter GRANT next cycle.
REQ-017 In IDLE, req_ready SHALL be all-zero and grant_valid SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_full && !(fifo_wr_en && fifo_almost_full), and all other req_ready bits SHALL be 0.
REQ-019 A transfer SHALL occur when req_valid[grant_id] && req_ready[grant_id] are both high.
REQ-020 A transfer SHALL be written to the FIFO exactly 1 cycle later as registered fifo_wr_en=1 with fifo_wr_data = that requester's req_data word.
REQ-021 fifo_wr_en SHALL be 0 in every cycle that does not follow a transfer.
REQ-022 A beat counter SHALL count transfers within the grant, 0..BURST_LEN-1.
REQ-023 GRANT SHALL return to IDLE when a transfer occurs with beat count = BURST_LEN-1, or when req_valid[grant_id] is 0.
REQ-024 On leaving GRANT, rr_ptr SHALL become (grant_id+1) mod N_REQ and the beat counter SHALL clear.
REQ-025 Each change of holder SHALL cost exactly one IDLE cycle.
REQ-026 With a single active requester, it SHALL be re-granted after that IDLE cycle.
REQ-027 While fifo_full is high, the grant SHALL be held, the beat count SHALL be held, and no transfer SHALL occur; no word is ever dropped or duplicated.

Reset
REQ-028 While rst is high, the block SHALL drive state=IDLE, rr_ptr=0, beat count=0, fifo_wr_en=0, fifo_wr_data=0, grant_valid=0, grant_id=0, req_ready=0.
REQ-029 Reset asserted mid-burst SHALL abort the grant at the next clock edge, and a transfer registered in that cycle SHALL NOT be written.

Configuration
REQ-030 With macro FIFO_WR_ARBITER_STATS_EN defined, the block SHALL add output grant_cnt, N_REQ*16 bits: per-requester 16-bit transfer counters that increment on each transfer, saturate at 0xFFFF, and clear on rst.
REQ-031 Without FIFO_WR_ARBITER_STATS_EN, port grant_cnt and its counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: after reset, req_valid=4'b1111 held, FIFO never full -> grants 0,1,2,3,0 in order, each of 4 beats, one IDLE cycle between grants.
REQ-033 The bench SHALL cover: req_valid=4'b0100, requester 2 streaming 10 words -> bursts of 4,4,2 beats; FIFO receives the 10 words in order, each 1 cycle after its transfer.
REQ-034 The bench SHALL cover: fifo_full forced high for 5 cycles mid-burst -> req_ready=0 and fifo_wr_en=0 for those cycles; the burst resumes at the held beat count with no loss.
REQ-035 The bench SHALL cover: FIFO depth 16 filled by back-to-back writes -> exactly 16 fifo_wr_en pulses, with no write while fifo_full=1.
REQ-036 The bench SHALL cover: rst pulsed during beat 2 of a grant -> all outputs 0 on the next cycle, rr_ptr=0, and the first grant after reset follows REQ-016.
REQ-037 The bench SHALL cover: with FIFO_WR_ARBITER_STATS_EN defined, 6 transfers from requester 1 -> grant_cnt[31:16]=6 and all other counters 0.
